// File: rtl/sha_k_stream.sv
// sha_k_stream: SHA-2 round-constant streamer.
// It holds the 80x64 SHA-512 K table. The SHA-256 table is the top 32 bits of
// the first 64 entries, so both widths share one table.
// A registered-address ROM read feeds a 2-entry skid FIFO. The FIFO head drives
// the valid/ready output, which sustains one beat per cycle under backpressure.
module sha_k_stream #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_idx,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (!((WIDTH == 32 && DEPTH == 64) || (WIDTH == 64 && DEPTH == 80))) begin : g_bad_cfg
    $error("sha_k_stream: WIDTH/DEPTH must be 32/64 or 64/80");
  end
  if ((2 ** ADDR_W) < DEPTH) begin : g_bad_addr
    $error("sha_k_stream: ADDR_W too small for DEPTH");
  end

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_P   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } beat_t;

  state_t            state, state_nx;
  logic              done_nx, err_nx;
  logic [ADDR_W:0]   rd_ptr;     // one extra bit so the DEPTH compare never wraps
  logic              rd_vld;     // ROM read in flight
  logic [ADDR_W-1:0] rd_addr;    // registered ROM address
  beat_t [1:0]       fifo;       // fifo[0] is the head
  logic [1:0]        cnt;
  logic [1:0]        occ;
  logic [63:0]       rom_row;
  beat_t             nb;
  logic              pop, push, issue, flush, ld, start_ok;

  assign rom_row   = K512[rd_addr];
  assign nb.data   = rom_row[63 -: WIDTH];
  assign nb.idx    = rd_addr;
  assign nb.last   = (rd_addr == LAST_A);

  assign out_valid = (cnt != 2'd0);
  assign out_data  = fifo[0].data;
  assign out_idx   = fifo[0].idx;
  assign out_last  = fifo[0].last;
  assign busy      = (state == RUN);

  assign start_ok  = ({1'b0, start_idx} < DEPTH_P);
  assign pop       = out_valid && out_ready;
  assign push      = rd_vld;
  assign flush     = (state == RUN) && abort;
  assign ld        = (state == IDLE) && start && start_ok && !abort;
  assign occ       = cnt + {1'b0, rd_vld};
  // occ never exceeds 2, so "room, or full with a pop this cycle" reduces to this
  assign issue     = (state == RUN) && (rd_ptr < DEPTH_P) && ((occ < 2'd2) || pop);

  // FSM state and the one-cycle done/err pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      err   <= err_nx;
    end
  end

  // Next state: abort beats both start and the final handshake
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !start_ok)   err_nx = 1'b1;
        else if (start && !abort) state_nx = RUN;
      end
      RUN: begin
        if (abort) state_nx = IDLE;
        else if (pop && fifo[0].last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read pointer and the registered ROM address; a flush drops the in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      rd_vld  <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_vld <= issue && !flush;
      if (issue) rd_addr <= rd_ptr[ADDR_W-1:0];
      if (ld)         rd_ptr <= {1'b0, start_idx};
      else if (issue) rd_ptr <= rd_ptr + ONE_P;
    end
  end

  // Two-entry skid FIFO; the issue rule guarantees room for every landing read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo <= '0;
      cnt  <= 2'd0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          fifo[cnt[0]] <= nb;
          cnt          <= cnt + 2'd1;
        end
        2'b01: begin
          fifo[0] <= fifo[1];
          cnt     <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) fifo[0] <= nb;
          else begin
            fifo[0] <= fifo[1];
            fifo[1] <= nb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
